// File: rtl/clk_div_tap_select.sv
// Turns one selected tap of a 4-bit divider counter into a single-cycle clock enable.
// Ratio changes are staged and committed only when the counter wraps to zero.
module clk_div_tap_select #(
  parameter logic [1:0] DEFAULT_SEL = 2'd0,
  parameter int         COUNT_W     = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [3:0]         tap,
  input  logic [1:0]         sel,
  input  logic               sel_valid,
  output logic               sel_ready,
  output logic               clk_en,
  output logic               div_out,
  output logic [1:0]         active_sel,
  output logic               switch_pending,
  output logic [COUNT_W-1:0] pulse_count
);

  localparam logic ST_RUN  = 1'b0;
  localparam logic ST_PEND = 1'b1;

  logic               state_q, state_d;
  logic [3:0]         tap_q;
  logic               act_q, act_d;
  logic               clk_en_q, clk_en_d;
  logic               div_out_q, div_out_d;
  logic [1:0]         active_sel_q, active_sel_d;
  logic [1:0]         next_sel_q, next_sel_d;
  logic [COUNT_W-1:0] pulse_count_q, pulse_count_d;

  logic tap_level;
  logic pulse;
  logic commit;
  logic accept;

  // Handshake: a request transfers on a clock edge where sel_valid && sel_ready;
  // sel_ready is a pure state decode, and while a switch is pending the request
  // inputs are ignored, so requesters hold sel/sel_valid until sel_ready is high.
  always_comb begin
    tap_level     = tap_q[active_sel_q];
    pulse         = tap_level & ~act_q;
    commit        = (state_q == ST_PEND) && (tap_q == 4'b0000);
    accept        = (state_q == ST_RUN) && sel_valid;

    state_d       = state_q;
    next_sel_d    = next_sel_q;
    active_sel_d  = active_sel_q;
    act_d         = tap_level;
    clk_en_d      = pulse;
    div_out_d     = tap_level;
    pulse_count_d = pulse_count_q + {{(COUNT_W-1){1'b0}}, pulse};

    if (accept && (sel != active_sel_q)) begin
      state_d    = ST_PEND;
      next_sel_d = sel;
    end

    // Committing at tap_q == 0 keeps every enable period whole across the switch.
    if (commit) begin
      state_d       = ST_RUN;
      active_sel_d  = next_sel_q;
      act_d         = 1'b0;
      clk_en_d      = 1'b0;
      pulse_count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_RUN;
      tap_q         <= 4'b0000;
      act_q         <= 1'b0;
      clk_en_q      <= 1'b0;
      div_out_q     <= 1'b0;
      active_sel_q  <= DEFAULT_SEL;
      next_sel_q    <= DEFAULT_SEL;
      pulse_count_q <= '0;
    end else begin
      state_q       <= state_d;
      tap_q         <= tap;
      act_q         <= act_d;
      clk_en_q      <= clk_en_d;
      div_out_q     <= div_out_d;
      active_sel_q  <= active_sel_d;
      next_sel_q    <= next_sel_d;
      pulse_count_q <= pulse_count_d;
    end
  end

  assign sel_ready      = (state_q == ST_RUN);
  assign switch_pending = (state_q == ST_PEND);
  assign clk_en         = clk_en_q;
  assign div_out        = div_out_q;
  assign active_sel     = active_sel_q;
  assign pulse_count    = pulse_count_q;

endmodule

// File: tb/tb_clk_div_tap_select.sv
// Directed bench for clk_div_tap_select: startup table, ratio switches, PEND behaviour,
// asynchronous reset during a pending switch and pulse counter wrap.
module tb_clk_div_tap_select;

  logic       clk;
  logic       reset_n;
  logic [3:0] tap;
  logic [1:0] sel;
  logic       sel_valid;
  logic       sel_ready;
  logic       clk_en;
  logic       div_out;
  logic [1:0] active_sel;
  logic       switch_pending;
  logic [7:0] pulse_count;

  int   total;
  int   bad;
  int   edge_n;
  logic free_run;

  typedef struct {
    logic [1:0] sel;
    logic       sel_valid;
    logic       exp_clk_en;
    logic       exp_div;
    logic       exp_pend;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs[8];

  clk_div_tap_select #(
    .DEFAULT_SEL(2'd0),
    .COUNT_W    (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tap           (tap),
    .sel           (sel),
    .sel_valid     (sel_valid),
    .sel_ready     (sel_ready),
    .clk_en        (clk_en),
    .div_out       (div_out),
    .active_sel    (active_sel),
    .switch_pending(switch_pending),
    .pulse_count   (pulse_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h want %0h", name, edge_n, got, exp);
    end
  endtask

  // Counter model: the tap value presented at edge k is (k-1) mod 16.
  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (free_run) tap = 4'(edge_n % 16);
  endtask

  function automatic logic bitof(input int v, input int b);
    logic [31:0] t;
    t = v;
    return t[b];
  endfunction

  initial begin
    int   tally;
    logic done;

    total = 0; bad = 0; edge_n = 0; free_run = 1'b0;
    reset_n = 1'b0; tap = 4'd0; sel = 2'd0; sel_valid = 1'b0;

    vecs[0] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[1] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
    vecs[2] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1};
    vecs[3] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
    vecs[4] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2};
    vecs[5] = '{2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd2};
    vecs[6] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3};
    vecs[7] = '{2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd3};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_clk_en", clk_en, 0);
    chk("rst_div_out", div_out, 0);
    chk("rst_count", pulse_count, 0);
    chk("rst_active", active_sel, 0);
    chk("rst_pending", switch_pending, 0);
    chk("rst_ready", sel_ready, 1);

    reset_n = 1'b1;
    edge_n = 0;
    free_run = 1'b1;

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      sel_valid = vecs[i].sel_valid;
      tick();
      chk("tbl_clk_en", clk_en, vecs[i].exp_clk_en);
      chk("tbl_div_out", div_out, vecs[i].exp_div);
      chk("tbl_pending", switch_pending, vecs[i].exp_pend);
      chk("tbl_ready", sel_ready, !vecs[i].exp_pend);
      chk("tbl_count", pulse_count, vecs[i].exp_cnt);
    end
    sel_valid = 1'b0;

    for (int k = 9; k <= 21; k++) begin
      tick();
      chk("div2_clk_en", clk_en, k % 2);
      chk("div2_div_out", div_out, k % 2);
      chk("div2_count", pulse_count, (k - 1) / 2);
    end
    chk("ten_pulses", pulse_count, 10);

    // Request div16 while tap = 5.
    sel = 2'd3; sel_valid = 1'b1;
    tick();
    chk("sw3_pending", switch_pending, 1);
    chk("sw3_ready", sel_ready, 0);
    sel_valid = 1'b0;
    for (int k = 23; k <= 33; k++) begin
      tick();
      chk("sw3_hold_pend", switch_pending, 1);
      chk("sw3_hold_en", clk_en, k % 2);
    end
    chk("sw3_precommit_cnt", pulse_count, 16);
    chk("sw3_precommit_act", active_sel, 0);
    tick();
    chk("sw3_commit_act", active_sel, 3);
    chk("sw3_commit_cnt", pulse_count, 0);
    chk("sw3_commit_en", clk_en, 0);
    chk("sw3_commit_pend", switch_pending, 0);
    for (int k = 35; k <= 58; k++) begin
      tick();
      chk("div16_clk_en", clk_en, (k == 42 || k == 58));
      chk("div16_div_out", div_out, bitof((k - 2) % 16, 3));
      chk("div16_count", pulse_count, (k >= 58) ? 2 : (k >= 42) ? 1 : 0);
    end

    sel = 2'd2; sel_valid = 1'b1;
    tick();
    chk("sw2_pending", switch_pending, 1);
    sel_valid = 1'b0;
    for (int k = 60; k <= 65; k++) begin
      tick();
      chk("sw2_hold_pend", switch_pending, 1);
      chk("sw2_hold_en", clk_en, 0);
    end
    tick();
    chk("sw2_commit_act", active_sel, 2);
    chk("sw2_commit_cnt", pulse_count, 0);
    chk("sw2_commit_pend", switch_pending, 0);
    for (int k = 67; k <= 80; k++) begin
      if (k == 72) begin
        sel = 2'd2; sel_valid = 1'b1;
      end
      tick();
      chk("div8_clk_en", clk_en, (k == 70 || k == 78));
      chk("div8_count", pulse_count, (k >= 78) ? 2 : (k >= 70) ? 1 : 0);
      if (k == 72) begin
        chk("same_sel_pend", switch_pending, 0);
        chk("same_sel_ready", sel_ready, 1);
        sel_valid = 1'b0;
      end
    end

    tick();
    tick();
    sel = 2'd3; sel_valid = 1'b1;
    tick();
    chk("ign_pending", switch_pending, 1);
    for (int k = 84; k <= 97; k++) begin
      sel = 2'(k % 4);
      sel_valid = logic'(k % 2);
      tick();
      chk("ign_hold_pend", switch_pending, 1);
      chk("ign_hold_act", active_sel, 2);
    end
    sel_valid = 1'b0;
    tick();
    chk("ign_commit_act", active_sel, 3);
    chk("ign_commit_pend", switch_pending, 0);
    chk("ign_commit_cnt", pulse_count, 0);

    tick();
    sel = 2'd1; sel_valid = 1'b1;
    tick();
    chk("rstp_pending", switch_pending, 1);
    sel_valid = 1'b0;
    for (int k = 101; k <= 108; k++) tick();
    chk("rstp_pre_div", div_out, 1);
    chk("rstp_pre_cnt", pulse_count, 1);
    chk("rstp_pre_pend", switch_pending, 1);
    #3;
    reset_n = 1'b0;
    #1;
    chk("arst_clk_en", clk_en, 0);
    chk("arst_div_out", div_out, 0);
    chk("arst_count", pulse_count, 0);
    chk("arst_active", active_sel, 0);
    chk("arst_pending", switch_pending, 0);
    chk("arst_ready", sel_ready, 1);
    repeat (3) tick();
    reset_n = 1'b1;

    tally = 0;
    done = 1'b0;
    for (int c = 0; c < 700 && !done; c++) begin
      tick();
      if (c == 20 || c == 39) begin
        chk("post_rst_active", active_sel, 0);
        chk("post_rst_pend", switch_pending, 0);
      end
      if (clk_en) begin
        tally++;
        if (tally == 255) chk("wrap_255", pulse_count, 255);
        if (tally == 256) begin
          chk("wrap_0", pulse_count, 0);
          done = 1'b1;
        end
      end
    end
    chk("wrap_reached", done, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
